match_argmax: RTL and testbench

- Downstream consumer of the popcount-match stage.
- Receives one match_count per library vector for the current image, streamed in library order.
- Tracks the maximum count and its library index, then emits one best-match result per image frame.
- Uses valid/ready handshakes on both sides so it chains directly behind the match stage's out_valid/next_ready.

---
 rtl/match_argmax_pkg.sv | 15 +
 rtl/match_argmax_cmp.sv | 77 +++++++
 rtl/match_argmax.sv | 99 +++++++++
 tb/tb_match_argmax.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/match_argmax_pkg.sv
// Shared constants and state type for the match-count argmax stage and the
// library-address generator that feeds the popcount-match stage.
package match_argmax_pkg;

  localparam int unsigned VEC_WIDTH    = 1100;
  localparam int unsigned POPCNT_WIDTH = $clog2(VEC_WIDTH + 1);
  localparam int unsigned LIB_DEPTH    = 1024;
  localparam int unsigned IDX_WIDTH    = $clog2(LIB_DEPTH);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/match_argmax_cmp.sv
// Registered compare/update of the running (idx, count[, second]) best tuple.
// Optional second-best tracking is enabled by MATCH_ARGMAX_SECOND_EN.
module match_argmax_cmp #(
  parameter int unsigned CNT_W     = match_argmax_pkg::POPCNT_WIDTH,
  parameter int unsigned IDX_W     = match_argmax_pkg::IDX_WIDTH,
  parameter int unsigned MIN_MATCH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             first,
  input  logic             last,
  input  logic [IDX_W-1:0] idx,
  input  logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] best_idx,
  output logic [CNT_W-1:0] best_count,
`ifdef MATCH_ARGMAX_SECOND_EN
  output logic [CNT_W-1:0] second_count,
  output logic             ambiguous,
`endif
  output logic             found
);

  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             found_nxt;

  // Strictly-greater replace keeps the lowest index on ties.
  always_comb begin
    idx_nxt = best_idx;
    cnt_nxt = best_count;
    if (first || (count > best_count)) begin
      idx_nxt = idx;
      cnt_nxt = count;
    end
    found_nxt = (cnt_nxt >= CNT_W'(MIN_MATCH)) && (cnt_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_idx   <= '0;
      best_count <= '0;
      found      <= 1'b0;
    end else if (load) begin
      best_idx   <= idx_nxt;
      best_count <= cnt_nxt;
      if (last) found <= found_nxt;
    end
  end

`ifdef MATCH_ARGMAX_SECOND_EN
  logic [CNT_W-1:0] sec_nxt;

  // Old best drops to second on a new max; ties with best also land in second.
  always_comb begin
    sec_nxt = second_count;
    if (first) begin
      sec_nxt = '0;
    end else if (count > best_count) begin
      sec_nxt = best_count;
    end else if ((count == best_count) || (count > second_count)) begin
      sec_nxt = count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_count <= '0;
      ambiguous    <= 1'b0;
    end else if (load) begin
      second_count <= sec_nxt;
      if (last) ambiguous <= found_nxt && (cnt_nxt == sec_nxt);
    end
  end
`endif

endmodule

// File: rtl/match_argmax.sv
// Best-match (argmax) over a streamed frame of library match counts, one
// registered result per frame. MATCH_ARGMAX_SECOND_EN adds second-best outputs.
module match_argmax #(
  parameter int unsigned POPCNT_WIDTH = match_argmax_pkg::POPCNT_WIDTH,
  parameter int unsigned LIB_DEPTH    = match_argmax_pkg::LIB_DEPTH,
  parameter int unsigned IDX_WIDTH    = $clog2(LIB_DEPTH),
  parameter int unsigned MIN_MATCH    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [POPCNT_WIDTH-1:0] match_count,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    this_ready,
  output logic                    out_valid,
  input  logic                    next_ready,
  output logic [IDX_WIDTH-1:0]    best_idx,
  output logic [POPCNT_WIDTH-1:0] best_count,
`ifdef MATCH_ARGMAX_SECOND_EN
  output logic [POPCNT_WIDTH-1:0] second_count,
  output logic                    ambiguous,
`endif
  output logic                    found
);

  import match_argmax_pkg::*;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_WIDTH-1:0] cur_idx;
  logic [IDX_WIDTH-1:0] idx_nxt;
  logic                 ready_nxt;
  logic                 valid_nxt;
  logic                 in_fire;
  logic                 frame_end;

  assign in_fire   = in_valid & this_ready;
  assign frame_end = in_last | (cur_idx == IDX_WIDTH'(LIB_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      cur_idx    <= '0;
      this_ready <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_idx    <= idx_nxt;
      this_ready <= ready_nxt;
      out_valid  <= valid_nxt;
    end
  end

  // Handshakes are registered from the next state so they align with it.
  always_comb begin
    state_nxt = state;
    idx_nxt   = cur_idx;
    case (state)
      ACCUM: begin
        if (in_fire) begin
          if (frame_end) begin
            idx_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            idx_nxt = cur_idx + IDX_WIDTH'(1);
          end
        end
      end
      HOLD: begin
        if (out_valid && next_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    ready_nxt = (state_nxt == ACCUM);
    valid_nxt = (state_nxt == HOLD);
  end

  match_argmax_cmp #(
    .CNT_W     (POPCNT_WIDTH),
    .IDX_W     (IDX_WIDTH),
    .MIN_MATCH (MIN_MATCH)
  ) u_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (in_fire),
    .first        (cur_idx == '0),
    .last         (frame_end),
    .idx          (cur_idx),
    .count        (match_count),
    .best_idx     (best_idx),
    .best_count   (best_count),
`ifdef MATCH_ARGMAX_SECOND_EN
    .second_count (second_count),
    .ambiguous    (ambiguous),
`endif
    .found        (found)
  );

endmodule

// File: tb/tb_match_argmax.sv
// Directed bench for match_argmax: default instance plus a MIN_MATCH=10 twin
// fed the same stream. MATCH_ARGMAX_SECOND_EN adds second-best checks.
module tb_match_argmax;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] match_count;
  logic        in_last;
  logic        in_valid;
  logic        next_ready;
  logic        this_ready, out_valid, found;
  logic [9:0]  best_idx;
  logic [10:0] best_count;
  logic        this_ready_m, out_valid_m, found_m;
  logic [9:0]  best_idx_m;
  logic [10:0] best_count_m;
`ifdef MATCH_ARGMAX_SECOND_EN
  logic [10:0] second_count, second_count_m;
  logic        ambiguous, ambiguous_m;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  match_argmax u_dut (
    .clk (clk), .rst_n (rst_n), .match_count (match_count), .in_last (in_last),
    .in_valid (in_valid), .this_ready (this_ready), .out_valid (out_valid),
    .next_ready (next_ready), .best_idx (best_idx), .best_count (best_count),
`ifdef MATCH_ARGMAX_SECOND_EN
    .second_count (second_count), .ambiguous (ambiguous),
`endif
    .found (found)
  );

  match_argmax #(.MIN_MATCH(10)) u_dut_min (
    .clk (clk), .rst_n (rst_n), .match_count (match_count), .in_last (in_last),
    .in_valid (in_valid), .this_ready (this_ready_m), .out_valid (out_valid_m),
    .next_ready (next_ready), .best_idx (best_idx_m), .best_count (best_count_m),
`ifdef MATCH_ARGMAX_SECOND_EN
    .second_count (second_count_m), .ambiguous (ambiguous_m),
`endif
    .found (found_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Present one beat from the falling edge and hold it until accepted.
  task automatic send(input logic [10:0] c, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; match_count = c; in_last = l;
    while (!this_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called #1 after the edge that accepted the last beat.
  task automatic expect_result(input string tag, input int e_idx, input int e_cnt,
                               input bit e_found, input bit e_found_m,
                               input int e_sec, input bit e_amb);
    check({tag, ".out_valid"},  32'(out_valid),  32'(1));
    check({tag, ".this_ready"}, 32'(this_ready), 32'(0));
    check({tag, ".best_idx"},   32'(best_idx),   32'(e_idx));
    check({tag, ".best_count"}, 32'(best_count), 32'(e_cnt));
    check({tag, ".found"},      32'(found),      32'(e_found));
    check({tag, ".found_min10"}, 32'(found_m),   32'(e_found_m));
`ifdef MATCH_ARGMAX_SECOND_EN
    check({tag, ".second"},     32'(second_count), 32'(e_sec));
    check({tag, ".ambiguous"},  32'(ambiguous),    32'(e_amb));
`else
    if (e_sec < 0 || e_amb) begin end
`endif
  endtask

  // With next_ready=1 the result fires on the next edge: exactly one bubble.
  task automatic expect_drain(input string tag);
    @(posedge clk); #1;
    check({tag, ".drain_valid"}, 32'(out_valid),  32'(0));
    check({tag, ".drain_ready"}, 32'(this_ready), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; match_count = '0; next_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid",  32'(out_valid),  32'(0));
    check("rst.best_idx",   32'(best_idx),   32'(0));
    check("rst.best_count", 32'(best_count), 32'(0));
    check("rst.found",      32'(found),      32'(0));
`ifdef MATCH_ARGMAX_SECOND_EN
    check("rst.second",     32'(second_count), 32'(0));
    check("rst.ambiguous",  32'(ambiguous),    32'(0));
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.this_ready", 32'(this_ready), 32'(1));

    // 5,9,3,9: tie at idx 3 keeps idx 1
    send(11'd5, 1'b0); send(11'd9, 1'b0); send(11'd3, 1'b0); send(11'd9, 1'b1);
    expect_result("f1", 1, 9, 1'b1, 1'b0, 9, 1'b1);
    expect_drain("f1");

    send(11'd7, 1'b1);
    expect_result("single", 0, 7, 1'b1, 1'b0, 0, 1'b0);
    expect_drain("single");

    send(11'd4, 1'b0); send(11'd8, 1'b1);
    expect_result("f48", 1, 8, 1'b1, 1'b0, 4, 1'b0);
    expect_drain("f48");

    for (int i = 0; i < 4; i++) send(11'd0, i == 3);
    expect_result("zero", 0, 0, 1'b0, 1'b0, 0, 1'b0);
    expect_drain("zero");

    // Downstream stall with upstream pushing a new beat
    next_ready = 1'b0;
    send(11'd12, 1'b0); send(11'd30, 1'b1);
    expect_result("stall", 1, 30, 1'b1, 1'b1, 12, 1'b0);
    in_valid = 1'b1; match_count = 11'd99; in_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("stall.out_valid",  32'(out_valid),  32'(1));
      check("stall.this_ready", 32'(this_ready), 32'(0));
      check("stall.best_idx",   32'(best_idx),   32'(1));
      check("stall.best_count", 32'(best_count), 32'(30));
    end
    next_ready = 1'b1;
    @(posedge clk); #1;
    check("stall.fire_valid", 32'(out_valid),  32'(0));
    check("stall.fire_ready", 32'(this_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    expect_result("after_stall", 0, 99, 1'b1, 1'b1, 0, 1'b0);
    expect_drain("after_stall");

    // Full library without in_last: implicit frame end at idx 1023
    for (int i = 0; i < 1024; i++) send(11'((i == 1023) ? 500 : (i % 400)), 1'b0);
    expect_result("full", 1023, 500, 1'b1, 1'b1, 399, 1'b0);
    expect_drain("full");

    send(11'd3, 1'b0); send(11'd2, 1'b1);
    expect_result("post_full", 0, 3, 1'b1, 1'b0, 2, 1'b0);
    expect_drain("post_full");

    // Reset mid-frame discards the partial frame
    send(11'd50, 1'b0); send(11'd60, 1'b0);
    check("mid.best_count", 32'(best_count), 32'(60));
    @(negedge clk); rst_n = 1'b0; #1;
    check("mid_rst.best_count", 32'(best_count), 32'(0));
    check("mid_rst.best_idx",   32'(best_idx),   32'(0));
    check("mid_rst.out_valid",  32'(out_valid),  32'(0));
    @(negedge clk); rst_n = 1'b1;
    send(11'd20, 1'b0); send(11'd10, 1'b1);
    expect_result("post_rst", 0, 20, 1'b1, 1'b1, 10, 1'b0);
    expect_drain("post_rst");

    // Reset during HOLD drops the pending result
    next_ready = 1'b0;
    send(11'd5, 1'b1);
    check("hold.out_valid", 32'(out_valid), 32'(1));
    @(negedge clk); rst_n = 1'b0; #1;
    check("hold_rst.out_valid", 32'(out_valid), 32'(0));
    check("hold_rst.found",     32'(found),     32'(0));
    @(negedge clk); rst_n = 1'b1; next_ready = 1'b1;

    send(11'd6, 1'b0); send(11'd6, 1'b1);
    expect_result("tie66", 0, 6, 1'b1, 1'b0, 6, 1'b1);
    expect_drain("tie66");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
